// File: rtl/vector_square_collector.sv
// Streaming squarer: accepts elements over valid/ready, packs squares into a VECTOR_LEN x 32-bit bus.
// Optional running sum of accepted squares on sum_out when VSC_RUNNING_SUM_EN is defined.
module vector_square_collector #(
    parameter int unsigned VECTOR_LEN = 8,
    parameter int unsigned ELEM_W     = 8,
    parameter int unsigned CNT_W      = $clog2(VECTOR_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ELEM_W-1:0]        in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [VECTOR_LEN*32-1:0] out_bus,
    output logic [CNT_W-1:0]         elem_count
`ifdef VSC_RUNNING_SUM_EN
    ,
    output logic [31:0]              sum_out
`endif
);

    localparam int unsigned SQ_W  = 2 * ELEM_W;
    localparam int unsigned BUS_W = VECTOR_LEN * 32;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [BUS_W-1:0] bus_nxt;
    logic             out_valid_nxt;
    logic             in_ready_nxt;
    logic             accept;
    logic [SQ_W-1:0]  square;
    logic [31:0]      lane_sq;

    assign accept  = in_valid && in_ready;
    assign square  = SQ_W'(in_data) * SQ_W'(in_data);
    assign lane_sq = 32'(square);

`ifdef VSC_RUNNING_SUM_EN
    logic [31:0] sum_nxt;
    logic [32:0] sum_wide;

    assign sum_wide = {1'b0, sum_out} + 33'(lane_sq);
`endif

    // Next-state and next-output logic; flush overrides every other event
    always_comb begin
        state_nxt     = state;
        count_nxt     = elem_count;
        bus_nxt       = out_bus;
        out_valid_nxt = out_valid;
        in_ready_nxt  = in_ready;
`ifdef VSC_RUNNING_SUM_EN
        sum_nxt       = sum_out;
`endif
        if (flush) begin
            state_nxt     = ST_FILL;
            count_nxt     = '0;
            bus_nxt       = '0;
            out_valid_nxt = 1'b0;
            in_ready_nxt  = 1'b1;
`ifdef VSC_RUNNING_SUM_EN
            sum_nxt       = '0;
`endif
        end else begin
            case (state)
                ST_FILL: begin
                    in_ready_nxt  = 1'b1;
                    out_valid_nxt = 1'b0;
                    if (accept) begin
                        for (int unsigned i = 0; i < VECTOR_LEN; i++) begin
                            if (elem_count == CNT_W'(i)) begin
                                bus_nxt[i*32 +: 32] = lane_sq;
                            end
                        end
                        count_nxt = elem_count + CNT_W'(1);
`ifdef VSC_RUNNING_SUM_EN
                        sum_nxt   = sum_wide[31:0];
`endif
                        if (elem_count == CNT_W'(VECTOR_LEN - 1)) begin
                            state_nxt     = ST_FULL;
                            out_valid_nxt = 1'b1;
                            in_ready_nxt  = 1'b0;
                        end
                    end
                end
                ST_FULL: begin
                    in_ready_nxt = 1'b0;
                    if (out_valid && out_ready) begin
                        state_nxt     = ST_FILL;
                        count_nxt     = '0;
                        bus_nxt       = '0;
                        out_valid_nxt = 1'b0;
                        in_ready_nxt  = 1'b1;
`ifdef VSC_RUNNING_SUM_EN
                        sum_nxt       = '0;
`endif
                    end
                end
                default: begin
                    state_nxt = ST_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FILL;
            elem_count <= '0;
            out_bus    <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            state      <= state_nxt;
            elem_count <= count_nxt;
            out_bus    <= bus_nxt;
            out_valid  <= out_valid_nxt;
            in_ready   <= in_ready_nxt;
        end
    end

`ifdef VSC_RUNNING_SUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out <= '0;
        end else begin
            sum_out <= sum_nxt;
        end
    end

    // The accumulator must never wrap past 2^32-1
    assert property (@(posedge clk) disable iff (!rst_n)
        (accept && !flush && state == ST_FILL) |-> !sum_wide[32])
        else $error("vector_square_collector: running sum wrapped");
`endif

    // A presented vector stays put while downstream stalls (flush may still discard it)
    assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> $stable(out_bus))
        else $error("vector_square_collector: out_bus changed while stalled");

endmodule

// File: tb/tb_vector_square_collector.sv
// Directed bench for vector_square_collector with a queue-based reference model checked every cycle.
module tb_vector_square_collector;

    localparam int unsigned VECTOR_LEN = 8;
    localparam int unsigned ELEM_W     = 8;
    localparam int unsigned CNT_W      = $clog2(VECTOR_LEN + 1);
    localparam int unsigned BUS_W      = VECTOR_LEN * 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [ELEM_W-1:0]    in_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [BUS_W-1:0]     out_bus;
    logic [CNT_W-1:0]     elem_count;
`ifdef VSC_RUNNING_SUM_EN
    logic [31:0]          sum_out;
`endif

    int tests = 0;
    int fails = 0;

    vector_square_collector #(
        .VECTOR_LEN(VECTOR_LEN),
        .ELEM_W    (ELEM_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bus   (out_bus),
        .elem_count(elem_count)
`ifdef VSC_RUNNING_SUM_EN
        ,
        .sum_out   (sum_out)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the vector is just the list of squares accepted so far
    logic [31:0] q[$];
    bit          m_full  = 1'b0;
    bit          m_rdy   = 1'b0;
    int          m_deliv = 0;
    int          dut_deliv = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_full = 1'b0;
            m_rdy  = 1'b0;
        end else if (flush) begin
            q.delete();
            m_full = 1'b0;
            m_rdy  = 1'b1;
        end else if (m_full) begin
            if (out_ready) begin
                q.delete();
                m_full = 1'b0;
                m_rdy  = 1'b1;
                m_deliv++;
            end
        end else begin
            if (in_valid && m_rdy) begin
                q.push_back(32'(in_data) * 32'(in_data));
                if (q.size() == VECTOR_LEN) m_full = 1'b1;
            end
            m_rdy = !m_full;
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) dut_deliv++;
    end

    function automatic logic [BUS_W-1:0] model_bus();
        logic [BUS_W-1:0] b;
        b = '0;
        foreach (q[i]) b[i*32 +: 32] = q[i];
        return b;
    endfunction

    function automatic logic [31:0] model_sum();
        logic [31:0] s;
        s = '0;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("in_ready",   BUS_W'(in_ready),   BUS_W'(m_rdy));
        check("out_valid",  BUS_W'(out_valid),  BUS_W'(m_full));
        check("elem_count", BUS_W'(elem_count), BUS_W'(q.size()));
        check("out_bus",    out_bus,            model_bus());
`ifdef VSC_RUNNING_SUM_EN
        check("sum_out",    BUS_W'(sum_out),    BUS_W'(model_sum()));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ELEM_W-1:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk);
            ok = in_ready;
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept of %0d", d);
        end
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  BUS_W'(in_ready),   '0);
        check({tag, "_out_valid"}, BUS_W'(out_valid),  '0);
        check({tag, "_count"},     BUS_W'(elem_count), '0);
        check({tag, "_bus"},       out_bus,            '0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        check("rel_in_ready_before_edge", BUS_W'(in_ready), '0);
        tick();
        check("rel_in_ready_after_edge", BUS_W'(in_ready), BUS_W'(1));
    endtask

    initial begin
        int gaps[8]  = '{0, 3, 1, 2, 0, 1, 3, 2};
        int elems[8] = '{2, 3, 5, 7, 11, 13, 17, 19};
        int lit[8]   = '{1, 4, 9, 16, 25, 36, 49, 64};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        #1;
        check_reset_outputs("por");
        #11;
        rst_n = 1'b1;
        tick();
        check("first_edge_in_ready", BUS_W'(in_ready), BUS_W'(1));

        // Back-to-back 1..8
        for (int i = 1; i <= 8; i++) send(ELEM_W'(i));
        check("v1_out_valid", BUS_W'(out_valid), BUS_W'(1));
        check("v1_count", BUS_W'(elem_count), BUS_W'(8));
        for (int i = 0; i < 8; i++) check("v1_lane", BUS_W'(out_bus[i*32 +: 32]), BUS_W'(lit[i]));
`ifdef VSC_RUNNING_SUM_EN
        check("v1_sum", BUS_W'(sum_out), BUS_W'(204));
`endif
        deliver();

        // 255s with a 5-cycle stall while in_data toggles
        for (int i = 0; i < 8; i++) send(8'hFF);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = (k % 2 == 0) ? 8'h55 : 8'hAA;
            tick();
        end
        in_valid = 1'b0;
        check("stall_in_ready", BUS_W'(in_ready), '0);
        check("stall_lane0", BUS_W'(out_bus[31:0]), BUS_W'(32'h0000FE01));
        check("stall_lane7", BUS_W'(out_bus[7*32 +: 32]), BUS_W'(32'h0000FE01));
        deliver();
        check("post_del_out_valid", BUS_W'(out_valid), '0);
        check("post_del_in_ready", BUS_W'(in_ready), BUS_W'(1));
        check("post_del_bus", out_bus, '0);

        // 7,0,3 then flush alongside a 9
        send(8'd7); send(8'd0); send(8'd3);
        check("pre_flush_count", BUS_W'(elem_count), BUS_W'(3));
        in_valid = 1'b1; in_data = 8'd9; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_count", BUS_W'(elem_count), '0);
        check("flush_bus", out_bus, '0);
        for (int i = 10; i < 18; i++) send(ELEM_W'(i));
        check("refill_lane0", BUS_W'(out_bus[31:0]), BUS_W'(100));
        check("refill_lane7", BUS_W'(out_bus[7*32 +: 32]), BUS_W'(289));
        deliver();

        // Idle gaps between elements
        for (int i = 0; i < 8; i++) begin
            repeat (gaps[i]) tick();
            send(ELEM_W'(elems[i]));
        end
        check("gap_lane3", BUS_W'(out_bus[3*32 +: 32]), BUS_W'(49));
        check("gap_lane7", BUS_W'(out_bus[7*32 +: 32]), BUS_W'(361));
        deliver();

        // Async reset mid-vector
        for (int i = 1; i <= 5; i++) send(ELEM_W'(i + 20));
        check("mid_count", BUS_W'(elem_count), BUS_W'(5));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst_mid");
        release_reset();

        // Async reset while FULL
        for (int i = 0; i < 8; i++) send(8'd4);
        check("full_before_rst", BUS_W'(out_valid), BUS_W'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst_full");
        release_reset();

        // flush and out_ready together in FULL
        for (int i = 0; i < 8; i++) send(8'd6);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        check("fo_out_valid", BUS_W'(out_valid), '0);
        check("fo_in_ready", BUS_W'(in_ready), BUS_W'(1));
        check("fo_bus", out_bus, '0);
        tick();

        check("model_deliveries", BUS_W'(m_deliv), BUS_W'(4));
        check("dut_deliveries", BUS_W'(dut_deliv), BUS_W'(4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
